// File: rtl/keypad_entry_ctrl.sv
// keypad_entry_ctrl
//
// Sits between the keypad scanner and the 7-segment display / consumer.
// Each key press produces exactly one event. After the event the block waits
// until the key has been released for RELEASE_CYCLES consecutive cycles.
// Digit keys are shifted into a BCD entry buffer, with the newest digit in
// nibble 0. '*' clears the entry. '#' hands the entry to the consumer over a
// valid/ready handshake.
//
// Ports:
//   clk_i          system clock, rising edge
//   rst_i          synchronous active-high reset
//   scan_valid_i   scanner reports a key held this cycle
//   scan_code_i    one-hot key code: bit0..8='1'..'9', bit9='*', bit10='0', bit11='#'
//   digits_bcd_o   entry buffer, nibble 0 = most recent digit
//   digit_count_o  digits currently entered (0..NUM_DIGITS)
//   blank_mask_o   bit i set when digit i is not in use (display blanks it)
//   commit_valid_o committed value available
//   commit_value_o BCD value being committed
//   commit_ready_i consumer accepts the commit
//   overflow_o     one-cycle pulse: digit pressed while buffer full
//   bad_code_o     one-cycle pulse: scan_valid with a non-one-hot code in IDLE

module keypad_entry_ctrl #(
  parameter int NUM_DIGITS     = 4,
  parameter int RELEASE_CYCLES = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    scan_valid_i,
  input  logic [11:0]             scan_code_i,
  output logic [4*NUM_DIGITS-1:0] digits_bcd_o,
  output logic [3:0]              digit_count_o,
  output logic [NUM_DIGITS-1:0]   blank_mask_o,
  output logic                    commit_valid_o,
  output logic [4*NUM_DIGITS-1:0] commit_value_o,
  input  logic                    commit_ready_i,
  output logic                    overflow_o,
  output logic                    bad_code_o
);

  localparam int W   = 4 * NUM_DIGITS;
  localparam int RCW = (RELEASE_CYCLES < 2) ? 1 : $clog2(RELEASE_CYCLES + 1);

  // The release counter is compared against the value it holds on the last
  // quiet cycle, so the return to IDLE happens on the RELEASE_CYCLES-th
  // consecutive quiet edge rather than one cycle later.
  localparam logic [RCW-1:0] REL_LAST  = RCW'(RELEASE_CYCLES - 1);
  localparam logic [3:0]     COUNT_MAX = 4'(NUM_DIGITS);
  localparam logic [3:0]     KEY_STAR  = 4'd9;
  localparam logic [3:0]     KEY_ZERO  = 4'd10;
  localparam logic [3:0]     KEY_HASH  = 4'd11;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_RELEASE = 2'd1,
    COMMIT       = 2'd2
  } state_t;

  state_t         state_q;
  logic [RCW-1:0] relCnt_q;
  logic [W-1:0]   buf_q;
  logic [3:0]     digitCount_q;
  logic           commitValid_q;
  logic [W-1:0]   commitValue_q;
  logic           overflow_q;
  logic           badCode_q;

  logic           codeOneHot;
  logic [3:0]     keyIdx;
  logic [3:0]     keyDigit;

  // Key decode. The bit position of the code is only meaningful when the
  // code is one-hot. The IDLE logic checks codeOneHot before it uses keyIdx.
  always_comb begin
    keyIdx = 4'd0;
    for (int i = 0; i < 12; i++) begin
      if (scan_code_i[i]) keyIdx = 4'(i);
    end
  end

  assign codeOneHot = $onehot(scan_code_i);
  assign keyDigit   = (keyIdx == KEY_ZERO) ? 4'd0 : keyIdx + 4'd1;

  // Entry FSM. All state and all outputs are registered here.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      relCnt_q      <= '0;
      buf_q         <= '0;
      digitCount_q  <= '0;
      commitValid_q <= 1'b0;
      commitValue_q <= '0;
      overflow_q    <= 1'b0;
      badCode_q     <= 1'b0;
    end else begin
      overflow_q <= 1'b0;
      badCode_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (scan_valid_i) begin
            if (!codeOneHot) begin
              badCode_q <= 1'b1;
            end else if (keyIdx == KEY_STAR) begin
              buf_q        <= '0;
              digitCount_q <= '0;
              state_q      <= WAIT_RELEASE;
            end else if (keyIdx == KEY_HASH) begin
              if (digitCount_q != 4'd0) begin
                commitValue_q <= buf_q;
                commitValid_q <= 1'b1;
                state_q       <= COMMIT;
              end else begin
                state_q <= WAIT_RELEASE;
              end
            end else begin
              if (digitCount_q < COUNT_MAX) begin
                buf_q        <= (buf_q << 4) | W'(keyDigit);
                digitCount_q <= digitCount_q + 4'd1;
              end else begin
                overflow_q <= 1'b1;
              end
              state_q <= WAIT_RELEASE;
            end
          end
        end

        // Any scan_valid restarts the quiet run. This absorbs bounces
        // that are shorter than RELEASE_CYCLES.
        WAIT_RELEASE: begin
          if (scan_valid_i) begin
            relCnt_q <= '0;
          end else if (relCnt_q == REL_LAST) begin
            relCnt_q <= '0;
            state_q  <= IDLE;
          end else begin
            relCnt_q <= relCnt_q + 1'b1;
          end
        end

        // Keys are ignored while a commit is outstanding. The release wait
        // afterwards stops a held '#' from firing again.
        COMMIT: begin
          if (commit_ready_i) begin
            commitValid_q <= 1'b0;
            buf_q         <= '0;
            digitCount_q  <= '0;
            relCnt_q      <= '0;
            state_q       <= WAIT_RELEASE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  // Display blanking follows the registered count directly.
  always_comb begin
    blank_mask_o = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      blank_mask_o[i] = (i >= int'(digitCount_q));
    end
  end

  assign digits_bcd_o   = buf_q;
  assign digit_count_o  = digitCount_q;
  assign commit_valid_o = commitValid_q;
  assign commit_value_o = commitValue_q;
  assign overflow_o     = overflow_q;
  assign bad_code_o     = badCode_q;

endmodule

// File: doc/keypad_entry_ctrl.md
Name: keypad_entry_ctrl

Overview:
- Controller between the keypad scanner (12-bit one-hot scan code plus valid) and the 7-segment display / consumer logic.
- Converts raw scan results into single key events, one event per press: each press is accepted once, then the block waits for release.
- Assembles decimal digits into a BCD entry buffer shown on the display. '*' clears the entry. '#' commits it over a valid/ready handshake.

Parameters:
- NUM_DIGITS, 4, BCD digits held in the entry buffer (1..8).
- RELEASE_CYCLES, 4, consecutive cycles with scan_valid=0 required to treat a key as released (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- scan_valid  input  1  scanner reports a key held this cycle.
- scan_code  input  12  one-hot key code. Bit0..bit8 = '1'..'9', bit9 = '*', bit10 = '0', bit11 = '#'.
- digits_bcd  output  4*NUM_DIGITS  entry buffer. Digit 0 (LSB nibble) is the most recently entered.
- digit_count  output  4  number of digits entered, 0..NUM_DIGITS.
- blank_mask  output  NUM_DIGITS  bit i=1 when i >= digit_count (display blanks that digit).
- commit_valid  output  1  committed value available.
- commit_value  output  4*NUM_DIGITS  BCD value being committed.
- commit_ready  input  1  consumer accepts the commit.
- overflow  output  1  one-cycle pulse: a digit was pressed while the buffer was full.
- bad_code  output  1  one-cycle pulse: scan_valid=1 with a code that is not exactly one-hot, seen in IDLE.

Behaviour:
- Reset state:
  - All outputs 0, except blank_mask = all ones.
  - State = IDLE, release counter = 0.
  - Reset has priority over every other event in the same cycle. Asserting rst mid-commit drops commit_valid on the next edge and discards the entry.
- States: IDLE, WAIT_RELEASE, COMMIT.
- IDLE, at an edge with scan_valid=1:
  - Code not one-hot (zero or multi-hot): pulse bad_code next cycle, stay in IDLE, buffer unchanged.
  - Digit key with digit_count < NUM_DIGITS: shift the buffer left one nibble, insert the digit at nibble 0, digit_count += 1. Go to WAIT_RELEASE.
  - Digit key with digit_count = NUM_DIGITS: buffer unchanged, pulse overflow. Go to WAIT_RELEASE.
  - '*': clear the buffer, digit_count = 0. Go to WAIT_RELEASE.
  - '#' with digit_count > 0: latch commit_value = digits_bcd, assert commit_valid. Go to COMMIT.
  - '#' with digit_count = 0: no effect. Go to WAIT_RELEASE.
- Latency:
  - Buffer, count and blank_mask update on the same edge that samples the key, so they are visible one cycle after the first scan_valid=1 cycle.
  - commit_valid is likewise visible one cycle after the first scan_valid=1 cycle.
- WAIT_RELEASE:
  - Release counter increments on each cycle with scan_valid=0 and resets to 0 on any cycle with scan_valid=1.
  - When the counter reaches RELEASE_CYCLES, go to IDLE and clear the counter.
  - A held key therefore produces exactly one event, and bounces shorter than RELEASE_CYCLES are absorbed.
- COMMIT:
  - commit_valid and commit_value are held stable until the edge where commit_ready=1.
  - At that edge: commit_valid -> 0, buffer cleared, digit_count = 0, release counter cleared. Go to WAIT_RELEASE.
  - Key activity during COMMIT is ignored (no bad_code, no overflow).
  - commit_ready while commit_valid=0 is ignored.
- blank_mask is combinationally derived from the registered digit_count.
- overflow and bad_code are registered single-cycle pulses.

Test Plan:
1. Reset, then press '1' (scan_code=12'h001, scan_valid for 6 cycles), release 4 cycles, then press '6' (12'h020) -> after '1': digits_bcd=16'h0001, count=1, blank_mask=4'b1110. After '6': digits_bcd=16'h0016, count=2, blank_mask=4'b1100. One event per press; state back in IDLE after 4 release cycles.
2. Key held 20 cycles with a 2-cycle scan_valid dropout in the middle -> only one digit entered (count increments once).
3. Enter 1,2,3,4, then press '5' -> digits_bcd=16'h1234, count=4, overflow pulses for exactly 1 cycle, buffer unchanged. Then press '*' -> digits_bcd=0, count=0, blank_mask=4'b1111.
4. Enter 4,2, press '#', hold commit_ready=0 for 5 cycles, then raise it for 1 cycle -> commit_valid=1 with commit_value=16'h0042, stable for all 5 cycles. Next cycle commit_valid=0, count=0. A press of '7' during the stall has no effect.
5. scan_code=12'h003 with scan_valid=1 in IDLE -> bad_code pulses for 1 cycle, buffer unchanged. '#' with an empty buffer -> no commit_valid.
6. rst=1 for one cycle while in COMMIT with commit_valid=1 -> next cycle commit_valid=0, digits_bcd=0, count=0, blank_mask=4'b1111, state IDLE.
